// File: rtl/snake_game_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : snake_game_if
//  Description : Board-side bundle of the Snake game: four raw push buttons
//                in, 3-bit RGB plus active-low VGA syncs out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface snake_game_if;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [2:0] rgb_out;
    logic       h_sync_o;
    logic       v_sync_o;

    // Game core: samples the buttons, drives the display
    modport master (
        input  up, down, left, right,
        output rgb_out, h_sync_o, v_sync_o
    );

    // Board / bench: drives the buttons, observes the display
    modport slave (
        output up, down, left, right,
        input  rgb_out, h_sync_o, v_sync_o
    );
endinterface
`default_nettype wire

// File: rtl/snake_game.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : snake_game
//  Description : VGA Snake on a 40x30 grid of 16x16 cells (640x480@60).
//                Timing generator, button sync/debounce, direction control,
//                snake body shift register, LFSR apple, collision and colour.
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_game #(
    parameter int MAX_LEN         = 16,
    parameter int INIT_LEN        = 3,
    parameter int MOVE_FRAMES     = 8,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic         clk,
    input  logic         reset,
    snake_game_if.master bus
);
    localparam logic [9:0] H_LAST      = 10'd799;
    localparam logic [9:0] V_LAST      = 10'd524;
    localparam logic [9:0] H_ACTIVE    = 10'd640;
    localparam logic [9:0] V_ACTIVE    = 10'd480;
    localparam logic [9:0] HS_START    = 10'd656;
    localparam logic [9:0] HS_END      = 10'd751;
    localparam logic [9:0] VS_START    = 10'd490;
    localparam logic [9:0] VS_END      = 10'd491;
    localparam logic [9:0] TICK_V      = 10'd480;
    localparam logic [5:0] GRID_X_LAST = 6'd39;
    localparam logic [4:0] GRID_Y_LAST = 5'd29;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int FRAME_W = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
    localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [LEN_W-1:0]   LEN_MAX    = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   LEN_INIT   = LEN_W'(INIT_LEN);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(MOVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [9:0]         h_count_q, h_count_d, v_count_q, v_count_d;
    logic [2:0]         rgb_q, rgb_d;
    logic               h_sync_q, h_sync_d, v_sync_q, v_sync_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]         btn_db;
    logic [1:0]         dir_q, dir_d, next_dir_q, next_dir_d;
    logic [5:0]         seg_x_q [MAX_LEN];
    logic [5:0]         seg_x_d [MAX_LEN];
    logic [4:0]         seg_y_q [MAX_LEN];
    logic [4:0]         seg_y_d [MAX_LEN];
    logic [LEN_W-1:0]   len_q, len_d;
    logic [5:0]         apple_x_q, apple_x_d;
    logic [4:0]         apple_y_q, apple_y_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               game_over_q, game_over_d;

    // Combinational helpers
    logic               move_tick;
    logic [1:0]         req_dir;
    logic               req_valid;
    logic [5:0]         new_x, cell_x, apple_x_new;
    logic [4:0]         new_y, cell_y, apple_y_new;
    logic               eat, hit_border, hit_body, collide;
    logic               snake_px, apple_px, border_px, active;

    assign bus.rgb_out  = rgb_q;
    assign bus.h_sync_o = h_sync_q;
    assign bus.v_sync_o = v_sync_q;

    // Raw buttons enter a two-flop synchronizer, bit order {up,down,left,right}
    assign sync1_d = {bus.up, bus.down, bus.left, bus.right};
    assign sync2_d = sync1_q;

    // Per-button debouncer: accept a new level after DEBOUNCE_CYCLES
    // consecutive samples that differ from the accepted level
    for (genvar b = 0; b < 4; b++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             db_q, db_d;

        // Count disagreeing samples; any agreeing sample restarts the count
        always_comb begin
            cnt_d = '0;
            db_d  = db_q;
            if (sync2_q[b] != db_q) begin
                if (cnt_q == CNT_LAST) begin
                    db_d = sync2_q[b];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Debounce state registers
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                db_q  <= db_d;
            end
        end

        assign btn_db[b] = db_q;
    end

    // Raster counters: 800 clocks per line, 525 lines per frame
    always_comb begin
        h_count_d = h_count_q + 10'd1;
        v_count_d = v_count_q;
        if (h_count_q == H_LAST) begin
            h_count_d = '0;
            v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 10'd1;
        end
    end

    // Move tick fires at the start of vertical blank every MOVE_FRAMES frames
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        move_tick   = 1'b0;
        if ((h_count_q == '0) && (v_count_q == TICK_V)) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                move_tick   = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
        end
    end

    // Prioritised direction request and candidate head / collision / eat
    always_comb begin
        req_valid = |btn_db;
        if (btn_db[3])      req_dir = DIR_UP;
        else if (btn_db[2]) req_dir = DIR_DOWN;
        else if (btn_db[1]) req_dir = DIR_LEFT;
        else                req_dir = DIR_RIGHT;

        new_x = seg_x_q[0];
        new_y = seg_y_q[0];
        case (next_dir_q)
            DIR_UP:   new_y = seg_y_q[0] - 5'd1;
            DIR_DOWN: new_y = seg_y_q[0] + 5'd1;
            DIR_LEFT: new_x = seg_x_q[0] - 6'd1;
            default:  new_x = seg_x_q[0] + 6'd1;
        endcase

        eat        = (new_x == apple_x_q) && (new_y == apple_y_q);
        hit_border = (new_x == '0) || (new_x == GRID_X_LAST) ||
                     (new_y == '0) || (new_y == GRID_Y_LAST);
        // Segment 0 is the old head and cannot coincide with new_head; the
        // tail only counts when eating, since otherwise it vacates this tick
        hit_body   = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < len_q) &&
                (((LEN_W'(i) + LEN_W'(1)) != len_q) || eat) &&
                (seg_x_q[i] == new_x) && (seg_y_q[i] == new_y)) begin
                hit_body = 1'b1;
            end
        end
        collide = hit_border || hit_body;

        apple_x_new = 6'(lfsr_q[5:0] % 6'd38) + 6'd1;
        apple_y_new = 5'(lfsr_q[12:8] % 5'd28) + 5'd1;
    end

    // Next game state: steering, shifting body, growth and apple relocation
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i];
            seg_y_d[i] = seg_y_q[i];
        end
        len_d       = len_q;
        dir_d       = dir_q;
        next_dir_d  = next_dir_q;
        apple_x_d   = apple_x_q;
        apple_y_d   = apple_y_q;
        game_over_d = game_over_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        // Opposite directions differ only in bit 0, so a reversal is dir ^ 1
        if (req_valid && (req_dir != (dir_q ^ 2'b01))) begin
            next_dir_d = req_dir;
        end

        if (move_tick && !game_over_q) begin
            if (collide) begin
                game_over_d = 1'b1;
            end else begin
                dir_d      = next_dir_q;
                seg_x_d[0] = new_x;
                seg_y_d[0] = new_y;
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                if (eat) begin
                    if (len_q != LEN_MAX) begin
                        len_d = len_q + LEN_W'(1);
                    end
                    apple_x_d = apple_x_new;
                    apple_y_d = apple_y_new;
                end
            end
        end
    end

    // Pixel colour and syncs, computed from the current counters
    always_comb begin
        cell_x    = h_count_q[9:4];
        cell_y    = v_count_q[8:4];
        active    = (h_count_q < H_ACTIVE) && (v_count_q < V_ACTIVE);
        snake_px  = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < len_q) && (seg_x_q[i] == cell_x) && (seg_y_q[i] == cell_y)) begin
                snake_px = 1'b1;
            end
        end
        apple_px  = (cell_x == apple_x_q) && (cell_y == apple_y_q);
        border_px = (cell_x == '0) || (cell_x == GRID_X_LAST) ||
                    (cell_y == '0) || (cell_y == GRID_Y_LAST);

        rgb_d = 3'b000;
        if (active) begin
            if (snake_px)       rgb_d = game_over_q ? 3'b100 : 3'b010;
            else if (apple_px)  rgb_d = 3'b100;
            else if (border_px) rgb_d = 3'b001;
        end

        h_sync_d = !((h_count_q >= HS_START) && (h_count_q <= HS_END));
        v_sync_d = !((v_count_q >= VS_START) && (v_count_q <= VS_END));
    end

    // All registered state of the game, video and synchronizers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_count_q   <= '0;
            v_count_q   <= '0;
            rgb_q       <= '0;
            h_sync_q    <= 1'b1;
            v_sync_q    <= 1'b1;
            frame_cnt_q <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            dir_q       <= DIR_RIGHT;
            next_dir_q  <= DIR_RIGHT;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < INIT_LEN) ? 6'(20 - i) : 6'd0;
                seg_y_q[i] <= (i < INIT_LEN) ? 5'd15 : 5'd0;
            end
            len_q       <= LEN_INIT;
            apple_x_q   <= 6'd30;
            apple_y_q   <= 5'd15;
            lfsr_q      <= 16'hACE1;
            game_over_q <= 1'b0;
        end else begin
            h_count_q   <= h_count_d;
            v_count_q   <= v_count_d;
            rgb_q       <= rgb_d;
            h_sync_q    <= h_sync_d;
            v_sync_q    <= v_sync_d;
            frame_cnt_q <= frame_cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            dir_q       <= dir_d;
            next_dir_q  <= next_dir_d;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_d[i];
                seg_y_q[i] <= seg_y_d[i];
            end
            len_q       <= len_d;
            apple_x_q   <= apple_x_d;
            apple_y_q   <= apple_y_d;
            lfsr_q      <= lfsr_d;
            game_over_q <= game_over_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_snake_game.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_snake_game
//  Description : Directed self-checking bench for snake_game. Video frames
//                are skipped by briefly overriding the raster counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_game;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [9:0] fh, fv;
    logic [5:0] fax;
    logic [4:0] fay;

    snake_game_if bus ();

    snake_game #(
        .MAX_LEN         (16),
        .INIT_LEN        (3),
        .MOVE_FRAMES     (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #20 clk = ~clk;

    task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Place the raster at (h,v) for one edge, then let it run three clocks
    task jump_to(input logic [9:0] h, input logic [9:0] v);
        @(negedge clk);
        fh = h;
        fv = v;
        force dut.h_count_q = fh;
        force dut.v_count_q = fv;
        @(posedge clk);
        @(negedge clk);
        release dut.h_count_q;
        release dut.v_count_q;
        repeat (3) @(posedge clk);
    endtask

    // One snake move = eight passes through the (0,480) frame point
    task move();
        repeat (8) jump_to(10'd799, 10'd479);
    endtask

    task probe(input string tag, input int cx, input int cy, input logic [2:0] exp);
        jump_to(10'(cx * 16 + 4), 10'(cy * 16 + 4));
        @(negedge clk);
        check(tag, 32'(bus.rgb_out), 32'(exp));
    endtask

    // b: 0=up 1=down 2=left 3=right
    task press(input int b);
        @(negedge clk);
        bus.up    = (b == 0);
        bus.down  = (b == 1);
        bus.left  = (b == 2);
        bus.right = (b == 3);
        repeat (12) @(posedge clk);
        @(negedge clk);
        bus.up = 1'b0; bus.down = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    task do_reset();
        @(negedge clk);
        reset = 1'b0;
        #600;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bus.up = 1'b0; bus.down = 1'b0; bus.left = 1'b0; bus.right = 1'b0;

        // ---- Reset values and line timing ----
        #600;
        check("rst_hsync", 32'(bus.h_sync_o), 32'd1);
        check("rst_vsync", 32'(bus.v_sync_o), 32'd1);
        check("rst_rgb",   32'(bus.rgb_out),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 1460; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1)    check("rgb_border_00", 32'(bus.rgb_out), 32'd1);
            if (k == 641)  check("rgb_hblank",    32'(bus.rgb_out), 32'd0);
            if (k == 656)  check("hs_before",     32'(bus.h_sync_o), 32'd1);
            if (k == 657)  check("hs_fall",       32'(bus.h_sync_o), 32'd0);
            if (k == 752)  check("hs_last_low",   32'(bus.h_sync_o), 32'd0);
            if (k == 753)  check("hs_rise",       32'(bus.h_sync_o), 32'd1);
            if (k == 1457) check("hs_next_line",  32'(bus.h_sync_o), 32'd0);
        end
        jump_to(10'd799, 10'd489);
        @(negedge clk);
        check("vs_low",     32'(bus.v_sync_o), 32'd0);
        check("rgb_vblank", 32'(bus.rgb_out),  32'd0);
        jump_to(10'd799, 10'd491);
        @(negedge clk);
        check("vs_high", 32'(bus.v_sync_o), 32'd1);

        // ---- Straight run, reversal ignored, eat, border collision ----
        move();
        probe("head_21_15", 21, 15, 3'b010);
        probe("tail_vacated", 18, 15, 3'b000);
        @(negedge clk);
        bus.left = 1'b1;
        repeat (20) @(posedge clk);
        move();
        probe("no_reverse", 22, 15, 3'b010);
        repeat (8) move();
        check("len_after_eat", 32'(dut.len_q), 32'd4);
        probe("eaten_cell_green", 30, 15, 3'b010);
        probe("new_tail_27", 27, 15, 3'b010);
        check("apple_x_range", 32'((dut.apple_x_q >= 6'd1) && (dut.apple_x_q <= 6'd38)), 32'd1);
        check("apple_y_range", 32'((dut.apple_y_q >= 5'd1) && (dut.apple_y_q <= 5'd28)), 32'd1);
        repeat (8) move();
        check("alive_at_38", 32'(dut.game_over_q), 32'd0);
        move();
        check("border_over", 32'(dut.game_over_q), 32'd1);
        probe("dead_head_red", 38, 15, 3'b100);
        probe("border_blue", 39, 15, 3'b001);
        move();
        check("frozen_head_x", 32'(dut.seg_x_q[0]), 32'd38);
        @(negedge clk);
        bus.left = 1'b0;

        // ---- Asynchronous reset mid-line ----
        jump_to(10'd700, 10'd100);
        @(negedge clk);
        check("hs_low_pre_rst", 32'(bus.h_sync_o), 32'd0);
        #3 reset = 1'b0;
        #1;
        check("async_rst_hs",   32'(bus.h_sync_o),    32'd1);
        check("async_rst_hcnt", 32'(dut.h_count_q),   32'd0);
        check("async_rst_over", 32'(dut.game_over_q), 32'd0);
        #600;
        @(negedge clk);
        reset = 1'b1;

        // ---- Turn up, then right ----
        press(0);
        move();
        probe("up_head_20_14", 20, 14, 3'b010);
        probe("up_tail_gone", 18, 15, 3'b000);
        press(3);
        move();
        probe("right_head_21_14", 21, 14, 3'b010);
        probe("right_tail_gone", 19, 15, 3'b000);
        check("turn_head_y", 32'(dut.seg_y_q[0]), 32'd14);

        // ---- Grow to 5 and bite own body ----
        do_reset();
        repeat (10) move();
        check("len4_again", 32'(dut.len_q), 32'd4);
        @(negedge clk);
        fax = 6'd31;
        fay = 5'd15;
        force dut.apple_x_q = fax;
        force dut.apple_y_q = fay;
        @(posedge clk);
        @(negedge clk);
        release dut.apple_x_q;
        release dut.apple_y_q;
        move();
        check("len5", 32'(dut.len_q), 32'd5);
        press(0);
        move();
        press(2);
        move();
        check("alive_before_bite", 32'(dut.game_over_q), 32'd0);
        press(1);
        move();
        check("self_over", 32'(dut.game_over_q), 32'd1);
        probe("self_head_red", 30, 14, 3'b100);
        probe("self_body_red", 31, 14, 3'b100);
        move();
        check("self_frozen_x", 32'(dut.seg_x_q[0]), 32'd30);
        check("self_frozen_y", 32'(dut.seg_y_q[0]), 32'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
